// File: rtl/fp_normalize_round_if.sv
// Bus bundle for the binary32 normalize-and-round stage: input beat handshake,
// leading-one detector results, and the packed result handshake.
interface fp_normalize_round_if;
    logic        in_valid;
    logic        in_ready;
    logic        sign;
    logic [7:0]  exp;
    logic [24:0] mant;
    logic [4:0]  position;
    logic        flag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;

    modport master (
        output in_valid, sign, exp, mant, position, flag, out_ready,
        input  in_ready, out_valid, result, overflow, underflow
    );

    modport slave (
        input  in_valid, sign, exp, mant, position, flag, out_ready,
        output in_ready, out_valid, result, overflow, underflow
    );
endinterface

// File: rtl/fp_normalize_round.sv
// Two-stage normalize / round-to-nearest-even / pack pipeline that turns the raw
// 25-bit mantissa sum of the binary32 adder into an IEEE-754 word.
module fp_normalize_round (
    input  logic                  clk,
    input  logic                  rst,
    fp_normalize_round_if.slave   bus
);

    logic               s1_valid_q, s1_valid_d;
    logic               s1_sign_q, s1_sign_d;
    logic               s1_zero_q, s1_zero_d;
    logic               s1_uf_q, s1_uf_d;
    logic [22:0]        s1_frac_q, s1_frac_d;
    logic               s1_rbit_q, s1_rbit_d;
    logic signed [9:0]  s1_exp_q, s1_exp_d;

    logic               s2_valid_q, s2_valid_d;
    logic [31:0]        result_q, result_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;

    logic               accept;
    logic               s2_load;
    logic [4:0]         shamt;
    logic signed [9:0]  e_norm;
    logic               inc;
    logic [23:0]        frac_rnd;
    logic signed [9:0]  e_rnd;

    assign bus.in_ready  = ~s1_valid_q | ~s2_valid_q | bus.out_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.result    = result_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

    assign accept  = bus.in_valid & bus.in_ready;
    assign s2_load = s1_valid_q & (~s2_valid_q | bus.out_ready);

    // exp - position + 1 covers both the carry case (k=0) and the left-shift case.
    always_comb begin
        shamt  = bus.position - 5'd1;
        e_norm = $signed({2'b00, bus.exp}) - $signed({5'b00000, bus.position}) + 10'sd1;

        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_zero_d  = s1_zero_q;
        s1_uf_d    = s1_uf_q;
        s1_frac_d  = s1_frac_q;
        s1_rbit_d  = s1_rbit_q;
        s1_exp_d   = s1_exp_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_sign_d  = bus.sign;
            s1_zero_d  = bus.flag;
            s1_exp_d   = e_norm;
            s1_uf_d    = (e_norm <= 10'sd0);
            if (bus.position == 5'd0) begin
                s1_frac_d = bus.mant[23:1];
                s1_rbit_d = bus.mant[0];
            end else begin
                s1_frac_d = bus.mant[22:0] << shamt;
                s1_rbit_d = 1'b0;
            end
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    // Only one bit is ever discarded, so a tie is the sole rounding case.
    always_comb begin
        inc      = s1_rbit_q & s1_frac_q[0];
        frac_rnd = {1'b0, s1_frac_q} + {23'd0, inc};
        e_rnd    = s1_exp_q + $signed({9'd0, frac_rnd[23]});

        s2_valid_d  = s2_valid_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (s2_load) begin
            s2_valid_d  = 1'b1;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            if (s1_zero_q) begin
                result_d = {s1_sign_q, 31'd0};
            end else if (s1_uf_q) begin
                result_d    = {s1_sign_q, 31'd0};
                underflow_d = 1'b1;
            end else if (e_rnd >= 10'sd255) begin
                result_d   = {s1_sign_q, 8'hFF, 23'd0};
                overflow_d = 1'b1;
            end else begin
                result_d = {s1_sign_q, e_rnd[7:0], frac_rnd[22:0]};
            end
        end else if (bus.out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_uf_q     <= 1'b0;
            s1_frac_q   <= 23'd0;
            s1_rbit_q   <= 1'b0;
            s1_exp_q    <= 10'sd0;
            s2_valid_q  <= 1'b0;
            result_q    <= 32'd0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_zero_q   <= s1_zero_d;
            s1_uf_q     <= s1_uf_d;
            s1_frac_q   <= s1_frac_d;
            s1_rbit_q   <= s1_rbit_d;
            s1_exp_q    <= s1_exp_d;
            s2_valid_q  <= s2_valid_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_fp_normalize_round.sv
// Directed-vector bench for fp_normalize_round: rounding, cancellation, limits,
// backpressure and mid-stream reset, all with hand-computed expected words.
module tb_fp_normalize_round;

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [24:0] mant;
        logic [4:0]  pos;
        logic        flag;
        logic [31:0] res;
        logic        ov;
        logic        uf;
    } vec_t;

    logic clk;
    logic rst;
    int   assertCount;
    int   failCount;
    vec_t vecs[14];
    int   bpList[4];

    fp_normalize_round_if bus();

    fp_normalize_round dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic driveBeat(input vec_t v);
        bus.sign     = v.sign;
        bus.exp      = v.exp;
        bus.mant     = v.mant;
        bus.position = v.pos;
        bus.flag     = v.flag;
    endtask

    // Presents one beat and holds it until it is taken, returning just after the capturing edge.
    task automatic applyStimulus(input vec_t v, input string tag);
        int   n;
        logic accepted;
        n        = 0;
        accepted = 1'b0;
        driveBeat(v);
        bus.in_valid = 1'b1;
        while (!accepted && n < 10) begin
            @(negedge clk);
            if (bus.in_ready) accepted = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        checkOutput({tag, "_accept"}, 32'(accepted), 32'd1);
    endtask

    task automatic runVector(input int i);
        int    n;
        string tag;
        tag = $sformatf("v%0d", i);
        bus.out_ready = 1'b1;
        applyStimulus(vecs[i], tag);
        @(negedge clk);
        checkOutput({tag, "_s1_only"}, 32'(bus.out_valid), 32'd0);
        n = 0;
        while (!bus.out_valid && n < 5) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        checkOutput({tag, "_result"}, bus.result, vecs[i].res);
        checkOutput({tag, "_overflow"}, 32'(bus.overflow), 32'(vecs[i].ov));
        checkOutput({tag, "_underflow"}, 32'(bus.underflow), 32'(vecs[i].uf));
        @(posedge clk);
        #1;
    endtask

    // Four beats with the output stalled for three cycles once the pipeline fills.
    task automatic backpressureTest();
        int   sent;
        int   got;
        int   cyc;
        logic acc;
        sent = 0;
        got  = 0;
        cyc  = 0;
        bus.out_ready = 1'b0;
        driveBeat(vecs[bpList[0]]);
        bus.in_valid = 1'b1;
        while (got < 4 && cyc < 30) begin
            if (cyc == 5) begin
                bus.out_ready = 1'b1;
                #1;
                checkOutput("bp_ready_comb", 32'(bus.in_ready), 32'd1);
            end
            @(negedge clk);
            if (cyc == 2) checkOutput("bp_ready_low", 32'(bus.in_ready), 32'd0);
            if (cyc >= 2 && cyc <= 4) begin
                checkOutput($sformatf("bp_hold_valid%0d", cyc), 32'(bus.out_valid), 32'd1);
                checkOutput($sformatf("bp_hold_result%0d", cyc), bus.result, vecs[bpList[0]].res);
            end
            if (bus.out_valid && bus.out_ready) begin
                checkOutput($sformatf("bp_out%0d", got), bus.result, vecs[bpList[got]].res);
                got++;
            end
            acc = bus.in_valid & bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                sent++;
                if (sent < 4) driveBeat(vecs[bpList[sent]]);
                else bus.in_valid = 1'b0;
            end
            cyc++;
        end
        bus.in_valid = 1'b0;
        checkOutput("bp_count", 32'(got), 32'd4);
        @(negedge clk);
        checkOutput("bp_drained", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic resetMidStream();
        bus.out_ready = 1'b0;
        driveBeat(vecs[3]);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        driveBeat(vecs[4]);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_pre_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("rst_pre_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_result", bus.result, 32'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("rst_no_stale%0d", i), 32'(bus.out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;

        vecs[0]  = '{1'b0, 8'd127, 25'h1000000, 5'd0,  1'b0, 32'h40000000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'd127, 25'h1000003, 5'd0,  1'b0, 32'h40000002, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'd127, 25'h1FFFFFF, 5'd0,  1'b0, 32'h40800000, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'd127, 25'h1000001, 5'd0,  1'b0, 32'h40000000, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 8'd127, 25'h0000002, 5'd23, 1'b0, 32'h34800000, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 8'd127, 25'h0000001, 5'd24, 1'b0, 32'h34000000, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 8'd127, 25'h0000000, 5'd0,  1'b1, 32'h80000000, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'd254, 25'h1000000, 5'd0,  1'b0, 32'h7F800000, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 8'd3,   25'h0004000, 5'd10, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 8'd1,   25'h0800000, 5'd1,  1'b0, 32'h00800000, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 8'd127, 25'h0C00000, 5'd1,  1'b0, 32'h3FC00000, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 8'd1,   25'h0400000, 5'd2,  1'b0, 32'h00000000, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 8'd253, 25'h1FFFFFF, 5'd0,  1'b0, 32'h7F800000, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 8'd127, 25'h1000000, 5'd0,  1'b0, 32'hC0000000, 1'b0, 1'b0};
        bpList   = '{0, 1, 2, 10};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        driveBeat(vecs[0]);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset_result", bus.result, 32'd0);
        checkOutput("reset_overflow", 32'(bus.overflow), 32'd0);
        checkOutput("reset_underflow", 32'(bus.underflow), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) runVector(i);

        backpressureTest();
        resetMidStream();
        runVector(13);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
